// File: rtl/cr16_pkg.sv
// Shared definitions for the CR16 fetch slice: IR field layout, opcodes, fetch sequencer states.
// Latency: none (types and constants only).
// Backpressure: none.
package cr16_pkg;

  localparam int INSTR_W     = 16;
  localparam int FIELD_W     = 4;
  localparam int IMM8_W      = 8;

  // IR field positions (LSB of each 4-bit field)
  localparam int IR_OP1_LSB  = 12;
  localparam int IR_COND_LSB = 8;   // also rDest
  localparam int IR_OP2_LSB  = 4;
  localparam int IR_SHFT_LSB = 0;   // also rSrc

  // Primary opcodes (opCode1) and the opCode2 values used under OPC_MEM
  localparam logic [3:0] OPC_RTYPE  = 4'b0000;
  localparam logic [3:0] OPC_BCOND  = 4'b1100;
  localparam logic [3:0] OPC_MEM    = 4'b0100;
  localparam logic [3:0] OPC2_JAL   = 4'b1000;
  localparam logic [3:0] OPC2_JCOND = 4'b1100;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_REQ  = 2'd1,
    FS_WAIT = 2'd2
  } fetch_state_e;

  // Sign-extend the low IR byte to a full instruction-width word
  function automatic logic [INSTR_W-1:0] sext8(input logic [IMM8_W-1:0] v);
    return {{(INSTR_W-IMM8_W){v[IMM8_W-1]}}, v};
  endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: one memory read per FSM fetch window, IDLE -> REQ -> WAIT -> IDLE.
// Latency: read strobe one cycle after the window opens; IR load strobe MEM_LAT cycles after the strobe.
// Backpressure: none; dropping next_instr_i mid-read aborts and discards the returning data.
module fetch_sequencer
  import cr16_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              next_instr_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_rd_en_o,
  output logic              fetch_busy_o,
  output logic              instr_valid_o,
  output logic              ir_load_o
);

  localparam int CNT_W = 2;

  fetch_state_e      state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              nxt_prev_q;
  logic              valid_q;
  logic              busy_q;
  logic              rd_en_q;
  logic [ADDR_W-1:0] addr_q;
  logic              start;

  // A new read starts on a fresh window (rising request) or while nothing valid is held
  assign start = (state_q == FS_IDLE) && next_instr_i && (!valid_q || !nxt_prev_q);

  // Capture only while the window is still open and the latency count has run out
  assign ir_load_o = (state_q == FS_WAIT) && next_instr_i && (cnt_q == '0);

  // Sequencer state, latency counter and registered memory/status outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= FS_IDLE;
      cnt_q      <= '0;
      nxt_prev_q <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      addr_q     <= '0;
    end else begin
      nxt_prev_q <= next_instr_i;
      case (state_q)
        FS_IDLE: begin
          if (start) begin
            state_q <= FS_REQ;
            addr_q  <= pc_i;       // PC before any same-edge increment
            rd_en_q <= 1'b1;
            busy_q  <= 1'b1;
            valid_q <= 1'b0;
          end
        end
        FS_REQ: begin
          rd_en_q <= 1'b0;
          cnt_q   <= CNT_W'(MEM_LAT - 1);
          if (!next_instr_i) begin
            state_q <= FS_IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= FS_WAIT;
          end
        end
        FS_WAIT: begin
          if (!next_instr_i) begin
            state_q <= FS_IDLE;
            busy_q  <= 1'b0;
          end else if (cnt_q == '0) begin
            state_q <= FS_IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= FS_IDLE;
      endcase
    end
  end

  assign mem_addr_o    = addr_q;
  assign mem_rd_en_o   = rd_en_q;
  assign fetch_busy_o  = busy_q;
  assign instr_valid_o = valid_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns PC/IR/imm/link, fetches via fetch_sequencer, splits IR fields.
// Latency: IR valid MEM_LAT+2 cycles after the fetch window opens; PC/imm/link update on the next edge.
// Backpressure: none; define IFU_RETIRE_CNT_EN to add the retireCount_o IR-load counter.
module instr_fetch_unit
  import cr16_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                MEM_LAT  = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               nextInstruction_i,
  input  logic               PCEN_i,
  input  logic               PCinstruction_i,
  input  logic               BranchEN_i,
  input  logic               JmpEN_i,
  input  logic               JALEN_i,
  input  logic               immediateRegEN_i,
  input  logic               zeroExtend_i,
  input  logic [ADDR_W-1:0]  jumpTarget_i,
  output logic [ADDR_W-1:0]  memAddr_o,
  output logic               memRdEn_o,
  input  logic [INSTR_W-1:0] memRdData_i,
  output logic [3:0]         opCode1_o,
  output logic [3:0]         opCode2_o,
  output logic [3:0]         conditionCode_o,
  output logic [3:0]         shiftAmt_o,
  output logic [3:0]         rDest_o,
  output logic [3:0]         rSrc_o,
  output logic [INSTR_W-1:0] imm_o,
  output logic [ADDR_W-1:0]  linkAddr_o,
  output logic               instrValid_o,
`ifdef IFU_RETIRE_CNT_EN
  output logic               fetchBusy_o,
  output logic [31:0]        retireCount_o
`else
  output logic               fetchBusy_o
`endif
);

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  link_q, link_d;
  logic [INSTR_W-1:0] ir_q;
  logic [INSTR_W-1:0] imm_q, imm_d;
  logic               ir_load;

  fetch_sequencer #(
    .ADDR_W  (ADDR_W),
    .MEM_LAT (MEM_LAT)
  ) u_seq (
    .clk_i         (clk_i),
    .rst_ni        (reset_ni),
    .next_instr_i  (nextInstruction_i),
    .pc_i          (pc_q),
    .mem_addr_o    (memAddr_o),
    .mem_rd_en_o   (memRdEn_o),
    .fetch_busy_o  (fetchBusy_o),
    .instr_valid_o (instrValid_o),
    .ir_load_o     (ir_load)
  );

  // PC redirect priority: jump, JAL, branch, then sequential increment only inside a fetch window
  always_comb begin
    pc_d   = pc_q;
    link_d = link_q;
    if (PCEN_i) begin
      if (JmpEN_i) begin
        pc_d = jumpTarget_i;
      end else if (JALEN_i) begin
        pc_d   = jumpTarget_i;
        link_d = pc_q;
      end else if (BranchEN_i) begin
        pc_d = pc_q + ADDR_W'($signed(ir_q[IMM8_W-1:0]));
      end else if (PCinstruction_i && nextInstruction_i) begin
        pc_d = pc_q + ADDR_W'(1);
      end
    end
  end

  // Immediate extension from the low IR byte, independent of any PC update
  always_comb begin
    imm_d = imm_q;
    if (immediateRegEN_i) begin
      imm_d = zeroExtend_i ? {{(INSTR_W-IMM8_W){1'b0}}, ir_q[IMM8_W-1:0]} : sext8(ir_q[IMM8_W-1:0]);
    end
  end

  // PC, link, IR and immediate registers
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      pc_q   <= RESET_PC;
      link_q <= '0;
      ir_q   <= '0;
      imm_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      link_q <= link_d;
      imm_q  <= imm_d;
      if (ir_load) ir_q <= memRdData_i;
    end
  end

`ifdef IFU_RETIRE_CNT_EN
  logic [31:0] retire_q;

  // Count completed IR loads, wrapping naturally at 2^32
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni)    retire_q <= '0;
    else if (ir_load) retire_q <= retire_q + 32'd1;
  end

  assign retireCount_o = retire_q;
`endif

  assign opCode1_o       = ir_q[IR_OP1_LSB  +: FIELD_W];
  assign conditionCode_o = ir_q[IR_COND_LSB +: FIELD_W];
  assign rDest_o         = ir_q[IR_COND_LSB +: FIELD_W];
  assign opCode2_o       = ir_q[IR_OP2_LSB  +: FIELD_W];
  assign shiftAmt_o      = ir_q[IR_SHFT_LSB +: FIELD_W];
  assign rSrc_o          = ir_q[IR_SHFT_LSB +: FIELD_W];
  assign imm_o           = imm_q;
  assign linkAddr_o      = link_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: directed spec scenarios plus randomized fetch/execute traffic.
// Expected fetch addresses, IR words, immediates and link values come from a reference model and queues.
// A negedge monitor pops and compares whenever the DUT strobes a read, loads the IR, or a timed value is due.
module tb_instr_fetch_unit;

  localparam int LAT    = 3;
  localparam int N_RAND = 300;

  typedef struct {
    int unsigned cyc;
    logic [15:0] val;
  } timed_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        nxt, pcen, pcinst, br_en, jmp_en, jal_en, imm_en, zext;
  logic [15:0] jtgt;
  logic [15:0] mem_addr, mem_rd_data, imm, link;
  logic        mem_rd_en, ivld, busy;
  logic [3:0]  op1, op2, cc, sh, rd, rs;
`ifdef IFU_RETIRE_CNT_EN
  logic [31:0] retire;
  int unsigned exp_retire = 0;
`endif

  int unsigned cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  logic [15:0] mem [0:65535];
  logic [15:0] pipe [LAT];

  logic [15:0] addr_q[$];
  logic [15:0] ir_exp_q[$];
  timed_t      imm_q[$];
  timed_t      link_q[$];

  // reference model state
  logic [15:0] pc_m, ir_m, imm_m, link_m;

  instr_fetch_unit #(
    .ADDR_W   (16),
    .MEM_LAT  (LAT),
    .RESET_PC (16'h0000)
  ) dut (
    .clk_i             (clk),
    .reset_ni          (reset_n),
    .nextInstruction_i (nxt),
    .PCEN_i            (pcen),
    .PCinstruction_i   (pcinst),
    .BranchEN_i        (br_en),
    .JmpEN_i           (jmp_en),
    .JALEN_i           (jal_en),
    .immediateRegEN_i  (imm_en),
    .zeroExtend_i      (zext),
    .jumpTarget_i      (jtgt),
    .memAddr_o         (mem_addr),
    .memRdEn_o         (mem_rd_en),
    .memRdData_i       (mem_rd_data),
    .opCode1_o         (op1),
    .opCode2_o         (op2),
    .conditionCode_o   (cc),
    .shiftAmt_o        (sh),
    .rDest_o           (rd),
    .rSrc_o            (rs),
    .imm_o             (imm),
    .linkAddr_o        (link),
    .instrValid_o      (ivld),
`ifdef IFU_RETIRE_CNT_EN
    .fetchBusy_o       (busy),
    .retireCount_o     (retire)
`else
    .fetchBusy_o       (busy)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Synchronous instruction memory: data for a strobe at cycle t is presented during cycle t+LAT
  always @(posedge clk) begin
    pipe[0] <= mem_rd_en ? mem[mem_addr] : 16'hDEAD;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rd_data = pipe[LAT-1];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // Monitor: compare whenever the DUT presents a read strobe, an IR load, or a due timed value
  logic iv_prev = 1'b0;
  always @(negedge clk) begin : mon
    logic [15:0] e;
    timed_t      t;
    if (reset_n) begin
      if (mem_rd_en) begin
        chk("read_expected", 32'(addr_q.size() > 0), 32'd1);
        if (addr_q.size() > 0) begin
          e = addr_q.pop_front();
          chk("fetch_addr", 32'(mem_addr), 32'(e));
          chk("busy_during_req", 32'(busy), 32'd1);
        end
      end
      if (ivld && !iv_prev) begin
        chk("ir_load_expected", 32'(ir_exp_q.size() > 0), 32'd1);
        if (ir_exp_q.size() > 0) begin
          e = ir_exp_q.pop_front();
          chk("ir_fields", 32'({op1, rd, op2, rs}), 32'(e));
          chk("ir_alias_fields", 32'({cc, sh}), 32'({e[11:8], e[3:0]}));
`ifdef IFU_RETIRE_CNT_EN
          exp_retire++;
          chk("retire_count", retire, exp_retire);
`endif
        end
      end
      while (imm_q.size() > 0 && imm_q[0].cyc <= cyc) begin
        t = imm_q.pop_front();
        chk("imm", 32'(imm), 32'(t.val));
      end
      while (link_q.size() > 0 && link_q[0].cyc <= cyc) begin
        t = link_q.pop_front();
        chk("link_addr", 32'(link), 32'(t.val));
      end
    end
    iv_prev = ivld;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    nxt = 1'b0; pcen = 1'b0; pcinst = 1'b0; br_en = 1'b0;
    jmp_en = 1'b0; jal_en = 1'b0; imm_en = 1'b0; zext = 1'b0;
  endtask

  // One execute-phase cycle (no fetch window) applying the FSM's PC/immediate controls
  task automatic exec(input bit p, input bit j, input bit l, input bit b, input bit pi,
                      input bit ie, input bit ze, input logic [15:0] tg);
    pcen = p; jmp_en = j; jal_en = l; br_en = b; pcinst = pi;
    imm_en = ie; zext = ze; jtgt = tg; nxt = 1'b0;
    if (p) begin
      if (j) pc_m = tg;
      else if (l) begin link_m = pc_m; pc_m = tg; end
      else if (b) pc_m = pc_m + 16'($signed(ir_m[7:0]));
      // sequential increment outside a fetch window leaves the PC alone
    end
    if (ie) imm_m = ze ? 16'(ir_m[7:0]) : 16'($signed(ir_m[7:0]));
    imm_q.push_back('{cyc + 1, imm_m});
    link_q.push_back('{cyc + 1, link_m});
    step();
    idle_inputs();
  endtask

  // Fetch window of 'hold' cycles; it completes only if held long enough to cover REQ plus LAT cycles
  task automatic do_fetch(input int hold, input bit inc);
    addr_q.push_back(pc_m);
    if (hold >= LAT + 2) begin
      ir_m = mem[pc_m];
      ir_exp_q.push_back(ir_m);
    end
    for (int i = 0; i < hold; i++) begin
      nxt    = 1'b1;
      pcen   = inc && (i == 0);
      pcinst = inc && (i == 0);
      step();
    end
    if (inc) pc_m = pc_m + 16'd1;
    idle_inputs();
    step();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_memRdEn"}, 32'(mem_rd_en), 32'd0);
    chk({tag, "_fetchBusy"}, 32'(busy), 32'd0);
    chk({tag, "_instrValid"}, 32'(ivld), 32'd0);
    chk({tag, "_ir"}, 32'({op1, rd, op2, rs}), 32'd0);
    chk({tag, "_imm"}, 32'(imm), 32'd0);
    chk({tag, "_linkAddr"}, 32'(link), 32'd0);
    chk({tag, "_memAddr"}, 32'(mem_addr), 32'd0);
`ifdef IFU_RETIRE_CNT_EN
    chk({tag, "_retire"}, retire, 32'd0);
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    mem[16'h0000] = 16'h5A13;
    mem[16'h0100] = 16'h12FC;
    mem[16'h0101] = 16'h3405;
    mem[16'h0200] = 16'h7780;
    idle_inputs();
    jtgt    = 16'h0000;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("por");
    reset_n = 1'b1;
    pc_m = 16'h0000; ir_m = 16'h0000; imm_m = 16'h0000; link_m = 16'h0000;
    step();

    // First fetch from address 0 with the FETCH-cycle increment
    do_fetch(LAT + 2, 1'b1);
    chk("first_ir", 32'({op1, rd, op2, rs}), 32'h5A13);
    chk("first_valid", 32'(ivld), 32'd1);
    do_fetch(LAT + 2, 1'b0);                       // must read address 0x0001

    // Backward branch: IR[7:0]=FC from PC 0x0010 lands on 0x000C
    exec(1, 1, 0, 0, 0, 0, 0, 16'h0100);
    do_fetch(LAT + 2, 1'b0);
    exec(1, 1, 0, 0, 0, 0, 0, 16'h0010);
    exec(1, 0, 0, 1, 0, 0, 0, 16'h0000);
    do_fetch(LAT + 2, 1'b0);
    // Forward branch: IR[7:0]=05 from PC 0x0010 lands on 0x0015
    exec(1, 1, 0, 0, 0, 0, 0, 16'h0101);
    do_fetch(LAT + 2, 1'b0);
    exec(1, 1, 0, 0, 0, 0, 0, 16'h0010);
    exec(1, 0, 0, 1, 0, 0, 0, 16'h0000);
    do_fetch(LAT + 2, 1'b0);

    // JAL from 0x0021 to 0x0400
    exec(1, 1, 0, 0, 0, 0, 0, 16'h0021);
    exec(1, 0, 1, 0, 0, 0, 0, 16'h0400);
    chk("jal_link", 32'(link), 32'h0021);
    do_fetch(LAT + 2, 1'b0);

    // PC wrap from 0xFFFF during fetch
    exec(1, 1, 0, 0, 0, 0, 0, 16'hFFFF);
    do_fetch(LAT + 2, 1'b1);
    do_fetch(LAT + 2, 1'b0);                       // must read address 0x0000

    // Immediate extension of IR[7:0]=0x80
    exec(1, 1, 0, 0, 0, 0, 0, 16'h0200);
    do_fetch(LAT + 2, 1'b0);
    exec(0, 0, 0, 0, 0, 1, 1, 16'h0000);
    chk("imm_zext", 32'(imm), 32'h0080);
    exec(0, 0, 0, 0, 0, 1, 0, 16'h0000);
    chk("imm_sext", 32'(imm), 32'hFF80);

    // Window dropped after 2 cycles: no IR capture, even when late data arrives
    do_fetch(2, 1'b0);
    repeat (LAT + 1) step();
    chk("abort_valid", 32'(ivld), 32'd0);
    chk("abort_ir", 32'({op1, rd, op2, rs}), 32'(ir_m));
    chk("abort_busy", 32'(busy), 32'd0);

    // Reset in the middle of WAIT
    addr_q.push_back(pc_m);
    nxt = 1'b1;
    step(); step(); step();
    reset_n = 1'b0;
    #1;
    chk_reset("mid_wait");
    idle_inputs();
    pc_m = 16'h0000; ir_m = 16'h0000; imm_m = 16'h0000; link_m = 16'h0000;
`ifdef IFU_RETIRE_CNT_EN
    exp_retire = 0;
`endif
    step(); step();
    reset_n = 1'b1;
    repeat (LAT + 2) step();
    chk("post_reset_valid", 32'(ivld), 32'd0);
    chk("post_reset_busy", 32'(busy), 32'd0);
    do_fetch(LAT + 2, 1'b1);                       // PC back at 0x0000

    // Randomized fetch windows (complete, aborted, over-held) mixed with execute cycles
    for (int n = 0; n < N_RAND; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        do_fetch(int'($urandom_range(1, LAT + 4)), 1'($urandom_range(0, 1)));
      end else begin
        exec(1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 5) == 0),
             1'($urandom_range(0, 5) == 0),
             1'($urandom_range(0, 3) == 0),
             1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)),
             16'($urandom));
      end
    end

    repeat (LAT + 4) step();
    chk("addr_q_drained", 32'(addr_q.size()), 32'd0);
    chk("ir_q_drained", 32'(ir_exp_q.size()), 32'd0);
    chk("imm_q_drained", 32'(imm_q.size()), 32'd0);
    chk("link_q_drained", 32'(link_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
